// File: rtl/seg7_scanner_if.sv
// Display-side bus of the 7-segment scanner: data/brightness in, scan drive out.
interface seg7_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  localparam int DW = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sev_out;
  logic                    dp_out;
  logic [DW-1:0]           digit_idx;
  logic                    frame_done;

  modport master (
    output value, load, dp, blank_mask, brightness,
    input  an, sev_out, dp_out, digit_idx, frame_done
  );
  modport slave (
    input  value, load, dp, blank_mask, brightness,
    output an, sev_out, dp_out, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scanner.sv
// Multiplexed 7-segment scanner with PWM brightness and frame-synchronous update.
// Optional leading-zero suppression enabled by defining SEG7_LZS_EN.
module seg7_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SUB_DIV    = 3125,
  parameter int BRIGHT_W   = 4
) (
  input logic clk,
  input logic Rst,
  seg7_scanner_if.slave bus
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int VW = 4*NUM_DIGITS;

  typedef struct packed {
    logic [VW-1:0]         val;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] blk;
  } disp_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [BRIGHT_W-1:0]   sub_q, sub_d, bright_q, bright_d;
  logic [DW-1:0]         dig_q, dig_d;
  disp_t                 pend_q, pend_d, act_q, act_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sev_q, sev_d;
  logic                  dp_out_q, dp_out_d, frame_done_q, frame_done_d;
  logic                  sub_wrap, slot_wrap, frame_wrap, lit, suppress;
  logic [3:0]            nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h01; 4'h1: hex7 = 7'h4F; 4'h2: hex7 = 7'h12; 4'h3: hex7 = 7'h06;
      4'h4: hex7 = 7'h4C; 4'h5: hex7 = 7'h24; 4'h6: hex7 = 7'h20; 4'h7: hex7 = 7'h0F;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h04; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h60;
      4'hC: hex7 = 7'h31; 4'hD: hex7 = 7'h42; 4'hE: hex7 = 7'h30; default: hex7 = 7'h38;
    endcase
  endfunction

  // Scan position, brightness sample and pending->active transfer.
  always_comb begin
    presc_d    = presc_q + 1'b1;
    sub_d      = sub_q;
    dig_d      = dig_q;
    bright_d   = bright_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    sub_wrap   = (presc_q == PW'(SUB_DIV-1));
    slot_wrap  = sub_wrap && (sub_q == '1);
    frame_wrap = slot_wrap && (dig_q == DW'(NUM_DIGITS-1));
    if (sub_wrap) begin
      presc_d = '0;
      sub_d   = sub_q + 1'b1;
    end
    if (slot_wrap) begin
      dig_d    = frame_wrap ? '0 : dig_q + 1'b1;
      bright_d = bus.brightness;
    end
    if (bus.load) begin
      pend_d     = '{val: bus.value, dp: bus.dp, blk: bus.blank_mask};
      pend_vld_d = 1'b1;
    end
    if (frame_wrap) begin
      if (pend_vld_d) act_d = pend_d;
      pend_vld_d = 1'b0;
    end
  end

`ifdef SEG7_LZS_EN
  // lz[i]: digit i and every digit above it are zero without a decimal point.
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (act_d.val[VW-1 -: 4] == 4'h0) && !act_d.dp[NUM_DIGITS-1];
    for (int i = NUM_DIGITS-2; i >= 1; i--)
      lz[i] = lz[i+1] && (act_d.val[4*i +: 4] == 4'h0) && !act_d.dp[i];
  end
  assign suppress = lz[dig_d];
`else
  assign suppress = 1'b0;
`endif

  // Outputs are decoded from the next scan position so an/sev/dp line up with digit_idx.
  always_comb begin
    nib      = act_d.val[4*dig_d +: 4];
    lit      = (sub_d <= bright_d) && !act_d.blk[dig_d] && !suppress;
    an_d     = '1;
    sev_d    = 7'h7F;
    dp_out_d = 1'b1;
    if (lit) begin
      an_d     = ~(NUM_DIGITS'(1) << dig_d);
      sev_d    = hex7(nib);
      dp_out_d = ~act_d.dp[dig_d];
    end
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      presc_q      <= '0;
      sub_q        <= '0;
      dig_q        <= '0;
      bright_q     <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      act_q        <= '0;
      an_q         <= '1;
      sev_q        <= 7'h7F;
      dp_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      sub_q        <= sub_d;
      dig_q        <= dig_d;
      bright_q     <= bright_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      act_q        <= act_d;
      an_q         <= an_d;
      sev_q        <= sev_d;
      dp_out_q     <= dp_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sev_out    = sev_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.digit_idx  = dig_q;
  assign bus.frame_done = frame_done_q;
endmodule
